// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with register storage. Top-of-stack is presented
// combinationally, and the status flags are decoded from count. Overflow and
// underflow are registered single-cycle pulses. When push and pop occur
// together on a non-empty stack, the top entry is replaced.
//
// push/pop semantics: these are requests with no ready handshake. A request
// that cannot be honoured (push while full, pop while empty) leaves all state
// unchanged and raises the matching pulse one cycle later.
module lifo_stack_param #(
  parameter int WIDTH     = 11,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 14,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_en;
  logic [CNT_W-1:0] count_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;

  // Status and top-of-stack are pure decodes of count and storage.
  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= AFULL_C);
  assign top_idx     = IDX_W'(count - ONE_C);
  assign dout        = empty ? '0 : mem[top_idx];

  // Decode the push/pop request against the current occupancy.
  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = '0;
    count_nxt = count;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          wr_en     = 1'b1;
          wr_idx    = IDX_W'(count);
          count_nxt = count + ONE_C;
        end else begin
          ovf_nxt = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) begin
          count_nxt = count - ONE_C;
        end else begin
          unf_nxt = 1'b1;
        end
      end
      2'b11: begin
        wr_en = 1'b1;
        if (empty) begin
          // Nothing to pop, so this behaves as a plain push into slot 0.
          wr_idx    = '0;
          count_nxt = ONE_C;
        end else begin
          // Replace the top entry; occupancy is unchanged, even when full.
          wr_idx = top_idx;
        end
      end
      default: ;
    endcase
  end

  // Occupancy and pulse registers: rst beats clr, and clr beats push/pop.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

  // Storage has no reset. Writes are suppressed while rst or clr is active.
  always_ff @(posedge clk) begin
    if (!rst && !clr && wr_en) begin
      mem[wr_idx] <= din;
    end
  end

endmodule
